// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the compare scheduler.
package fcmp_pkg;

  // Request operation encoding.
  typedef enum logic [1:0] {
    OP_LT  = 2'b00,
    OP_LE  = 2'b01,
    OP_EQ  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // Scheduler states, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMP1 = 2'd1;
  localparam state_t ST_CMP2 = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Value returned for a true comparison.
  localparam logic [31:0] RSP_TRUE = 32'h0000_0001;

  // Single-precision NaN: all-ones exponent with a nonzero mantissa.
  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fcmp_rr_arb.sv
// Parameterised round-robin arbiter. The search starts at the requester
// after the last grant; the pointer only moves when the grant is used.
module fcmp_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Find the first active request at or after the pointer, wrapping at NREQ.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] j;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      j = sum[IW-1:0];
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

  // Next priority is the requester just after the one being granted.
  always_comb begin
    ptr_d = ptr_q;
    if (adv && any) ptr_d = (idx == IW'(NREQ-1)) ? '0 : idx + IW'(1);
  end

  // Pointer register; reset gives requester 0 the highest priority.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one multi-cycle FLT less-than unit between
// NREQ requesters. LE runs one swapped LT, EQ runs LT both ways, NaN and
// reserved ops are answered without the unit, and a watchdog bounds each
// unit phase.
module fcmp_sched
  import fcmp_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  input  logic [NREQ*2-1:0]       req_op,
  output logic [31:0]             cu_a,
  output logic [31:0]             cu_b,
  output logic                    cu_start,
  input  logic                    cu_z_stb,
  input  logic [31:0]             cu_z,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_z,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  // Only bit 0 of the unit result carries information.
  logic cu_z_unused;
  assign cu_z_unused = ^cu_z[31:1];

  state_t         state_q, state_d;
  logic [IW-1:0]  id_q, id_d;
  op_e            op_q, op_d;
  logic           z_q, z_d;
  logic           err_q, err_d;
  logic           lt1_q, lt1_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [31:0]    cu_a_q, cu_a_d;
  logic [31:0]    cu_b_q, cu_b_d;
  logic           cu_start_q, cu_start_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            any_req;
  logic            accept;
  logic [31:0]     sel_a, sel_b;
  op_e             sel_op;

  // A grant is only taken in IDLE; the pointer advances on that accept.
  assign accept = (state_q == ST_IDLE) && any_req && !rst;

  fcmp_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .adv   (accept),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  // Route the granted requester's operands and op to the decode logic.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = OP_LT;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*32 +: 32];
        sel_b  = req_b[i*32 +: 32];
        sel_op = op_e'(req_op[i*2 +: 2]);
      end
    end
  end

  // Sequencer: decode at accept, run one or two unit phases, then respond.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    op_d       = op_q;
    z_d        = z_q;
    err_d      = err_q;
    lt1_d      = lt1_q;
    wd_d       = wd_q;
    cu_a_d     = cu_a_q;
    cu_b_d     = cu_b_q;
    cu_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d  = gidx;
          op_d  = sel_op;
          z_d   = 1'b0;
          err_d = 1'b0;
          wd_d  = '0;
          if (is_nan(sel_a) || is_nan(sel_b)) begin
            state_d = ST_RESP;
          end else if (sel_op == OP_RSV) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d    = ST_CMP1;
            cu_start_d = 1'b1;
            // a<=b is evaluated as !(b<a).
            if (sel_op == OP_LE) begin
              cu_a_d = sel_b;
              cu_b_d = sel_a;
            end else begin
              cu_a_d = sel_a;
              cu_b_d = sel_b;
            end
          end
        end
      end
      ST_CMP1: begin
        if (cu_z_stb) begin
          if (op_q == OP_EQ) begin
            lt1_d      = cu_z[0];
            state_d    = ST_CMP2;
            cu_start_d = 1'b1;
            wd_d       = '0;
            cu_a_d     = cu_b_q;
            cu_b_d     = cu_a_q;
          end else begin
            z_d     = (op_q == OP_LT) ? cu_z[0] : !cu_z[0];
            state_d = ST_RESP;
          end
        end else if (wd_q == WD_MAX) begin
          z_d     = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_CMP2: begin
        if (cu_z_stb) begin
          z_d     = !lt1_q && !cu_z[0];
          state_d = ST_RESP;
        end else if (wd_q == WD_MAX) begin
          z_d     = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      op_q       <= OP_LT;
      z_q        <= 1'b0;
      err_q      <= 1'b0;
      lt1_q      <= 1'b0;
      wd_q       <= '0;
      cu_a_q     <= '0;
      cu_b_q     <= '0;
      cu_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      op_q       <= op_d;
      z_q        <= z_d;
      err_q      <= err_d;
      lt1_q      <= lt1_d;
      wd_q       <= wd_d;
      cu_a_q     <= cu_a_d;
      cu_b_q     <= cu_b_d;
      cu_start_q <= cu_start_d;
    end
  end

  assign req_ready = accept ? grant : '0;
  assign cu_a      = cu_a_q;
  assign cu_b      = cu_b_q;
  assign cu_start  = cu_start_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_z     = (rsp_valid && z_q) ? RSP_TRUE : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed bench for fcmp_sched with a latency-programmable compare unit model.
module tb_fcmp_sched;
  import fcmp_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic [31:0]       cu_a, cu_b, cu_z, rsp_z;
  logic              cu_start, cu_z_stb, rsp_valid, rsp_err, busy;
  logic [0:0]        rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fcmp_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .cu_a(cu_a), .cu_b(cu_b), .cu_start(cu_start),
    .cu_z_stb(cu_z_stb), .cu_z(cu_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- compare unit model ----------------
  int lat_cfg   = 3;
  bit model_en  = 1'b1;
  bit force_stb = 1'b0;
  bit model_stb = 1'b0;
  int cnt       = 0;

  function automatic bit flt_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  always @(posedge clk) begin
    #1;
    model_stb = 1'b0;
    if (rst || !model_en) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) model_stb = 1'b1;
      end
      if (cu_start) begin
        if (lat_cfg == 0) model_stb = 1'b1;
        else cnt = lat_cfg;
      end
    end
  end

  assign cu_z_stb = model_stb | force_stb;
  assign cu_z     = {31'd0, flt_lt(cu_a, cu_b)};

  // ---------------- monitor ----------------
  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] z;
    logic        err;
  } rsp_t;

  int          cyc = 0;
  rsp_t        rsp_q[$];
  int          acc_cyc_q[$];
  int          acc_id_q[$];
  int          start_cnt = 0;
  logic [31:0] first_a, last_a;
  int          ready_bad = 0;
  rsp_t        mon_r;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      acc_cyc_q.push_back(cyc);
      acc_id_q.push_back(req_ready[1] ? 1 : 0);
      if (!$onehot(req_ready)) ready_bad++;
    end
    if (cu_start) begin
      if (start_cnt == 0) first_a = cu_a;
      last_a = cu_a;
      start_cnt++;
    end
    if (rsp_valid) begin
      mon_r.cyc = cyc;
      mon_r.id  = int'(rsp_id);
      mon_r.z   = rsp_z;
      mon_r.err = rsp_err;
      rsp_q.push_back(mon_r);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int t_acc, output bit ok);
    int n0;
    n0 = acc_cyc_q.size();
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r*2 +: 2]  = op;
    req_valid[r]      = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      if (acc_cyc_q.size() > n0) ok = 1'b1;
    end
    req_valid[r] = 1'b0;
    t_acc = ok ? acc_cyc_q[n0] : -1;
  endtask

  task automatic wait_rsp(output rsp_t r, output bit ok);
    ok = 1'b0;
    r.cyc = -1; r.id = -1; r.z = '0; r.err = 1'b0;
    for (int k = 0; k < 300 && rsp_q.size() == 0; k++) tick();
    if (rsp_q.size() > 0) begin
      r  = rsp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_cu_a"},      cu_a,            32'd0);
    check({tag, "_cu_b"},      cu_b,            32'd0);
    check({tag, "_cu_start"},  32'(cu_start),   32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid),  32'd0);
    check({tag, "_rsp_id"},    32'(rsp_id),     32'd0);
    check({tag, "_rsp_z"},     rsp_z,           32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),    32'd0);
    check({tag, "_busy"},      32'(busy),       32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        z;
    logic        err;
    int          starts;
    int          rsp_lat;
    logic [31:0] first_a;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int   t;
    bit   ok;
    rsp_t r;
    int   n0;
    int   r0;

    // op a b unit-latency z err starts accept->rsp first-cu_a
    vecs[0]  = '{OP_LT,  32'h40000000, 32'h40a9999a, 3, 1'b1, 1'b0, 1, 5, 32'h40000000};
    vecs[1]  = '{OP_LT,  32'h40a9999a, 32'h40000000, 3, 1'b0, 1'b0, 1, 5, 32'h40a9999a};
    vecs[2]  = '{OP_LE,  32'h40200000, 32'h40000000, 3, 1'b0, 1'b0, 1, 5, 32'h40000000};
    vecs[3]  = '{OP_LE,  32'h40000000, 32'h40000000, 1, 1'b1, 1'b0, 1, 3, 32'h40000000};
    vecs[4]  = '{OP_EQ,  32'h40000000, 32'h40000000, 3, 1'b1, 1'b0, 2, 9, 32'h40000000};
    vecs[5]  = '{OP_EQ,  32'h40000000, 32'h40200000, 2, 1'b0, 1'b0, 2, 7, 32'h40000000};
    vecs[6]  = '{OP_LT,  32'h7fc00000, 32'h3f800000, 3, 1'b0, 1'b0, 0, 1, 32'h0};
    vecs[7]  = '{OP_EQ,  32'h3f800000, 32'h7f800001, 3, 1'b0, 1'b0, 0, 1, 32'h0};
    vecs[8]  = '{OP_RSV, 32'h3f800000, 32'h3f800000, 3, 1'b0, 1'b1, 0, 1, 32'h0};
    vecs[9]  = '{OP_LT,  32'hc0000000, 32'hbf800000, 0, 1'b1, 1'b0, 1, 2, 32'hc0000000};
    vecs[10] = '{OP_EQ,  32'h7f800000, 32'h7f800000, 0, 1'b1, 1'b0, 2, 3, 32'h7f800000};
    vecs[11] = '{OP_LE,  32'h80000000, 32'h00000000, 2, 1'b1, 1'b0, 1, 4, 32'h00000000};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Table-driven single requests on requester 0.
    for (int i = 0; i < 12; i++) begin
      lat_cfg   = vecs[i].lat;
      start_cnt = 0;
      issue(0, vecs[i].op, vecs[i].a, vecs[i].b, t, ok);
      check($sformatf("v%0d_accept", i), 32'(ok), 32'd1);
      wait_rsp(r, ok);
      check($sformatf("v%0d_rsp_seen", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_z", i),       r.z,             vecs[i].z ? RSP_TRUE : 32'd0);
      check($sformatf("v%0d_err", i),     32'(r.err),      32'(vecs[i].err));
      check($sformatf("v%0d_id", i),      32'(r.id),       32'd0);
      check($sformatf("v%0d_latency", i), 32'(r.cyc - t),  32'(vecs[i].rsp_lat));
      check($sformatf("v%0d_starts", i),  32'(start_cnt),  32'(vecs[i].starts));
      if (vecs[i].starts > 0)
        check($sformatf("v%0d_cu_a", i), first_a, vecs[i].first_a);
      if (vecs[i].starts == 2)
        check($sformatf("v%0d_cu_a_swapped", i), last_a, vecs[i].b);
    end

    // Watchdog: the unit never strobes; a late strobe must be ignored.
    model_en  = 1'b0;
    start_cnt = 0;
    issue(0, OP_LT, 32'h40000000, 32'h40a9999a, t, ok);
    check("wd_accept", 32'(ok), 32'd1);
    wait_rsp(r, ok);
    check("wd_rsp_seen", 32'(ok), 32'd1);
    check("wd_latency",  32'(r.cyc - t), 32'(TIMEOUT + 2));
    check("wd_err",      32'(r.err), 32'd1);
    check("wd_z",        r.z, 32'd0);
    check("wd_starts",   32'(start_cnt), 32'd1);
    tick();
    tick();
    force_stb = 1'b1;
    tick();
    force_stb = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("late_strobe_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("late_strobe_idle",   32'(busy), 32'd0);
    model_en = 1'b1;

    // Reset while CMP1 is waiting; both requesters stay valid across it.
    lat_cfg = 3;
    issue(0, OP_LT, 32'h40000000, 32'h40a9999a, t, ok);
    check("rstmid_accept", 32'(ok), 32'd1);
    check("rstmid_in_cmp1", 32'(cu_start), 32'd1);
    req_a     = {32'h40000000, 32'h40000000};
    req_b     = {32'h40a9999a, 32'h40a9999a};
    req_op    = '0;
    req_valid = 2'b11;
    rst       = 1'b1;
    #1;
    check_idle_outputs("rstmid");
    tick();
    tick();
    n0 = acc_cyc_q.size();
    r0 = rsp_q.size();
    check("rstmid_no_rsp", 32'(r0), 32'd0);
    rst = 1'b0;

    // Fairness: both requesters continuously valid.
    for (int k = 0; k < 200 && acc_cyc_q.size() < n0 + 4; k++) tick();
    req_valid = '0;
    check("fair_accepts", 32'(acc_cyc_q.size() - n0), 32'd4);
    for (int k = 0; k < 300 && rsp_q.size() < 4; k++) tick();
    check("fair_rsps", 32'(rsp_q.size()), 32'd4);
    if (acc_cyc_q.size() >= n0 + 4 && rsp_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("fair_grant%0d", k), 32'(acc_id_q[n0 + k]), 32'(k % 2));
        check($sformatf("fair_rsp_id%0d", k), 32'(rsp_q[k].id), 32'(k % 2));
        check($sformatf("fair_rsp_z%0d", k), rsp_q[k].z, RSP_TRUE);
      end
      check("back_to_back", 32'(acc_cyc_q[n0 + 1]), 32'(rsp_q[0].cyc + 1));
    end
    check("ready_onehot", 32'(ready_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fcmp_sched.md
# fcmp_sched

Round-robin scheduler that shares one multi-cycle single-precision compare unit (the FLT less-than core) between NREQ requesters, e.g. FPU issue ports. It accepts LT/LE/EQ requests and sequences one or two LT operations on the shared unit, with operand swapping where needed. It resolves NaN operands without using the unit and returns a single-cycle tagged result pulse. A watchdog guards against a unit that never strobes.

## Interface
- NREQ, 2: number of requesters (2..8).
- TIMEOUT, 64: maximum cycles to wait for a unit strobe per phase.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request pending, per requester.
- req_ready  out  NREQ  one-hot acceptance pulse, per requester.
- req_a, req_b  in  NREQ×32  IEEE-754 single operands, per requester.
- req_op  in  NREQ×2  operation: 00 LT (a<b), 01 LE (a<=b), 10 EQ (a==b), 11 reserved.
- cu_a, cu_b  out  32  operands to the compare unit; held stable while waiting.
- cu_start  out  1  one-cycle launch pulse to the compare unit.
- cu_z_stb  in  1  unit result strobe.
- cu_z  in  32  unit result; only bit 0 is used (1 means cu_a<cu_b).
- rsp_valid  out  1  one-cycle result pulse; no backpressure.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- rsp_z  out  32  result, 32'h1 or 32'h0.
- rsp_err  out  1  reserved op or watchdog expiry.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CMP1, CMP2, RESP.
- **IDLE:**
  - If any req_valid is high, grant round-robin starting from the requester after the last grant. After reset, requester 0 has highest priority.
  - Pulse req_ready[g] in the same cycle, combinationally from IDLE plus the grant.
  - Latch a, b, op and id.
- **Decode at accept:**
  - NaN means exponent 8'hFF and mantissa nonzero. If either operand is NaN, go to RESP with z=0, err=0, and no unit use.
  - op 11: go to RESP with z=0, err=1.
  - LT: CMP1 with (a,b). Result is lt.
  - LE: CMP1 with (b,a). Result is !lt_swapped.
  - EQ: CMP1 with (a,b), then CMP2 with (b,a). Result is !lt1 && !lt2.
- **CMP1/CMP2:**
  - On entry, drive cu_a/cu_b and pulse cu_start for one cycle.
  - Wait for cu_z_stb and capture cu_z[0].
  - A watchdog counter counts waiting cycles. When it reaches TIMEOUT without a strobe, go to RESP with z=0, err=1.
- **RESP:**
  - Assert rsp_valid, rsp_id, rsp_z and rsp_err for one cycle, then return to IDLE.
- **Ignored or unchanged inputs:**
  - cu_z_stb is ignored outside CMP1/CMP2, including late strobes after a timeout.
  - req_valid of non-granted requesters has no effect until the next IDLE.
- **Reset:**
  - Asynchronous; all state returns to IDLE immediately.
  - Reset values: every output 0 (req_ready, cu_a, cu_b, cu_start, rsp_valid, rsp_id, rsp_z, rsp_err, busy).
  - The round-robin pointer resets so requester 0 has highest priority.
  - A request that was in flight is dropped with no response.

## Timing
- Accept at cycle T.
- NaN or reserved op: rsp_valid at T+1.
- LT or LE: cu_start at T+1. If the strobe arrives at cycle S, rsp_valid is at S+1.
- EQ: second cu_start at S1+1 after the first strobe at S1. rsp_valid is at S2+1.
- Strobe arriving in the same cycle as cu_start is legal and accepted.
- Back-to-back throughput: a new accept is possible in the cycle after RESP.
- Watchdog: rsp_err is asserted at T+1+TIMEOUT+1 for a phase that never strobes.

## Structure
- Package fcmp_pkg holds:
  - op encoding enum,
  - state enum,
  - is_nan function,
  - constant RSP_TRUE = 32'h1.
- Sub-module fcmp_rr_arb is a parameterised round-robin arbiter. It takes the req vector, an advance enable, and outputs a one-hot grant and encoded index.
- The compare unit is external. It is instantiated by the FPU top level, not inside fcmp_sched.

## Test plan
- **LT:** req0 a=40000000, b=40a9999a, op LT; unit model with 3-cycle latency. Expect one cu_start with cu_a=40000000, then rsp_valid 4 cycles later with rsp_z=1, rsp_id=0.
- **Fairness:** req0 and req1 continuously valid, op LT. Expect grants alternate 0,1,0,1 and rsp_id follows the same order.
- **EQ:** a=b=40000000. Expect two cu_start pulses, the second with swapped operands, and rsp_z=1. With a=40000000, b=40200000, expect rsp_z=0.
- **LE and NaN:**
  - LE with a=40200000, b=40000000: expect rsp_z=0.
  - a=7fc00000: expect rsp at T+1, z=0, and no cu_start.
- **Watchdog:** unit never strobes, TIMEOUT=64. Expect rsp_err=1, z=0 at the timeout cycle. A late strobe afterwards must produce no response.
- **Reset mid-CMP1:** all outputs are 0 in the same cycle and no response is produced. The next accept goes to requester 0.
